// File: rtl/off_chip_rx_buffer_pkg.sv
// Shared definitions for the off-chip link receive path: state encoding and default marker.
// Imported by the link stage, the receive buffer and the bench scoreboard.
package off_chip_rx_buffer_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } rx_state_e;

  localparam int unsigned     RX_DEPTH_DEF  = 4;
  localparam int unsigned     RX_AW_DEF     = 2;
  localparam int unsigned     RX_DW_DEF     = 8;
  localparam int unsigned     RX_CW_DEF     = 4;
  localparam logic [7:0]      RX_MARKER_DEF = 8'd5;

endpackage : off_chip_rx_buffer_pkg

// File: rtl/off_chip_rx_buffer_if.sv
// Link-side and consumer-side handshake bundle of the receive buffer.
// master = link stage / consumer side, slave = the buffer itself.
interface off_chip_rx_buffer_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2,
  parameter int unsigned CW = 4
);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          pause;
  logic          flush;
  logic [AW:0]   count;
  logic [CW-1:0] marker_cnt;

  modport master (
    output in_data, in_valid, out_ready, pause, flush,
    input  in_ready, out_data, out_valid, count, marker_cnt
  );

  modport slave (
    input  in_data, in_valid, out_ready, pause, flush,
    output in_ready, out_data, out_valid, count, marker_cnt
  );

endinterface : off_chip_rx_buffer_if

// File: rtl/off_chip_rx_buffer_mem.sv
// DEPTH x DW register array: synchronous write, asynchronous read, synchronous active-low clear.
// Read data follows raddr in the same cycle; no backpressure of its own.
module off_chip_rx_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : off_chip_rx_mem

// File: rtl/off_chip_rx_buffer.sv
// Receive buffer for the off-chip byte link: DEPTH-entry FWFT FIFO with pause/flush and marker tracking.
// One-cycle push-to-output latency; in_ready drops when full, paused or flushing.
module off_chip_rx_buffer
  import off_chip_rx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = RX_DEPTH_DEF,
  parameter int unsigned AW     = RX_AW_DEF,
  parameter int unsigned DW     = RX_DW_DEF,
  parameter logic [DW-1:0] MARKER = DW'(RX_MARKER_DEF),
  parameter int unsigned CW     = RX_CW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  off_chip_rx_buffer_if.slave   bus
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  rx_state_e     state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] marker_cnt_q, marker_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          push;
  logic          pop;
  logic          mark_in;
  logic          mark_out;
  logic [DW-1:0] head_dat;

  off_chip_rx_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clk   (clk),
    .clr_n (rst),
    .we    (push),
    .waddr (wptr_q),
    .wdata (bus.in_data),
    .raddr (rptr_q),
    .rdata (head_dat)
  );

  // Both handshakes use registered readiness, so no comb path from valid to ready.
  assign push     = bus.in_valid & in_ready_q;
  assign pop      = out_valid_q & bus.out_ready;
  assign mark_in  = push && (bus.in_data == MARKER);
  assign mark_out = pop && (head_dat == MARKER);

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    marker_cnt_d = marker_cnt_q;

    if (state_q == ST_FLUSH) begin
      wptr_d       = '0;
      rptr_d       = '0;
      count_d      = '0;
      marker_cnt_d = '0;
      state_d      = bus.pause ? ST_HOLD : ST_RUN;
    end else begin
      if (push) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (AW + 1)'(1);
      end

      // Saturate at the top, floor at zero.
      if (mark_in && !mark_out && (marker_cnt_q != '1)) begin
        marker_cnt_d = marker_cnt_q + CW'(1);
      end else if (mark_out && !mark_in && (marker_cnt_q != '0)) begin
        marker_cnt_d = marker_cnt_q - CW'(1);
      end

      if (bus.flush) begin
        state_d = ST_FLUSH;
      end else if (state_q == ST_RUN) begin
        state_d = bus.pause ? ST_HOLD : ST_RUN;
      end else begin
        state_d = bus.pause ? ST_HOLD : ST_RUN;
      end
    end

    in_ready_d  = (state_d == ST_RUN) && (count_d != FULL_CNT);
    out_valid_d = (count_d != '0) && (state_d != ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      marker_cnt_q <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      marker_cnt_q <= marker_cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = head_dat;
  assign bus.count      = count_q;
  assign bus.marker_cnt = marker_cnt_q;

endmodule : off_chip_rx_buffer

// File: tb/tb_off_chip_rx_buffer.sv
// Bench for off_chip_rx_buffer: directed scenarios then random traffic against a queue-based model.
module tb_off_chip_rx_buffer;
  import off_chip_rx_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  off_chip_rx_buffer_if #(.DW(8), .AW(2), .CW(4)) bus_if ();

  off_chip_rx_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: buffer contents as a queue plus the control state.
  logic [7:0] mq[$];
  rx_state_e  m_state = ST_RUN;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int marker_in_q();
    int n = 0;
    foreach (mq[i]) if (mq[i] == RX_MARKER_DEF) n++;
    return (n > 15) ? 15 : n;
  endfunction

  function automatic bit m_in_ready();
    return (m_state == ST_RUN) && (mq.size() != DEPTH);
  endfunction

  function automatic bit m_out_valid();
    return (mq.size() != 0) && (m_state != ST_FLUSH);
  endfunction

  task automatic check_all();
    check_eq("in_ready",   bus_if.in_ready,   m_in_ready());
    check_eq("out_valid",  bus_if.out_valid,  m_out_valid());
    check_eq("count",      bus_if.count,      mq.size());
    check_eq("marker_cnt", bus_if.marker_cnt, marker_in_q());
    if (m_out_valid()) check_eq("out_data", bus_if.out_data, mq[0]);
  endtask

  // One clock: drive inputs, advance the model at the edge, check at the falling edge.
  task automatic cyc(input bit r, input bit iv, input logic [7:0] d,
                     input bit ordy, input bit p, input bit f);
    bit ir;
    bit ov;
    rst              = r;
    bus_if.in_valid  = iv;
    bus_if.in_data   = d;
    bus_if.out_ready = ordy;
    bus_if.pause     = p;
    bus_if.flush     = f;
    ir = m_in_ready();
    ov = m_out_valid();
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_state = ST_RUN;
    end else if (m_state == ST_FLUSH) begin
      mq.delete();
      m_state = p ? ST_HOLD : ST_RUN;
    end else begin
      if (ov && ordy) void'(mq.pop_front());
      if (iv && ir) mq.push_back(d);
      if (f)      m_state = ST_FLUSH;
      else if (p) m_state = ST_HOLD;
      else        m_state = ST_RUN;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    bus_if.pause     = 1'b0;
    bus_if.flush     = 1'b0;
    @(negedge clk);

    // Reset
    cyc(0, 0, 8'h00, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 0);
    check_eq("rst_in_ready",  bus_if.in_ready,   1);
    check_eq("rst_out_valid", bus_if.out_valid,  0);
    check_eq("rst_count",     bus_if.count,      0);
    check_eq("rst_marker",    bus_if.marker_cnt, 0);
    check_eq("rst_out_data",  bus_if.out_data,   0);

    // Fill to full, fifth byte waits for a pop
    cyc(1, 1, 8'h11, 0, 0, 0);
    check_eq("fill_first_head", bus_if.out_data, 8'h11);
    cyc(1, 1, 8'h22, 0, 0, 0);
    cyc(1, 1, 8'h33, 0, 0, 0);
    cyc(1, 1, 8'h44, 0, 0, 0);
    check_eq("full_count",    bus_if.count,    4);
    check_eq("full_in_ready", bus_if.in_ready, 0);
    cyc(1, 1, 8'h55, 0, 0, 0);
    check_eq("full_hold",     bus_if.count,    4);
    cyc(1, 1, 8'h55, 1, 0, 0);
    check_eq("full_pop_count", bus_if.count,    3);
    check_eq("full_pop_head",  bus_if.out_data, 8'h22);
    cyc(1, 1, 8'h55, 0, 0, 0);
    check_eq("fifth_in",       bus_if.count,    4);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 1, 0, 0);
    check_eq("drained", bus_if.count, 0);

    // Continuous stream with pointer wrap
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 8'(i), 1, 0, 0);
      check_eq("stream_count", bus_if.count, 1);
      check_eq("stream_head",  bus_if.out_data, i);
    end
    cyc(1, 0, 8'h00, 1, 0, 0);

    // Marker tracking
    cyc(1, 1, 8'h05, 0, 0, 0);
    check_eq("mk_a", bus_if.marker_cnt, 1);
    cyc(1, 1, 8'h07, 0, 0, 0);
    check_eq("mk_b", bus_if.marker_cnt, 1);
    cyc(1, 1, 8'h05, 0, 0, 0);
    check_eq("mk_c", bus_if.marker_cnt, 2);
    cyc(1, 0, 8'h00, 1, 0, 0);
    check_eq("mk_pop", bus_if.marker_cnt, 1);
    cyc(1, 0, 8'h00, 1, 0, 0);
    cyc(1, 1, 8'h05, 1, 0, 0);
    check_eq("mk_both", bus_if.marker_cnt, 1);
    check_eq("mk_both_count", bus_if.count, 1);
    cyc(1, 0, 8'h00, 1, 0, 0);

    // Pause drains the output while blocking input
    cyc(1, 1, 8'hA1, 0, 0, 0);
    cyc(1, 1, 8'hA2, 0, 0, 0);
    cyc(1, 1, 8'hA3, 0, 0, 0);
    cyc(1, 0, 8'h00, 0, 1, 0);
    check_eq("pause_in_ready", bus_if.in_ready, 0);
    check_eq("pause_count",    bus_if.count,    3);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h09, 1, 1, 0);
    check_eq("pause_drain",     bus_if.count,    0);
    check_eq("pause_drain_rdy", bus_if.in_ready, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);
    check_eq("unpause_rdy", bus_if.in_ready, 1);

    // Flush
    cyc(1, 1, 8'h05, 0, 0, 0);
    cyc(1, 1, 8'h07, 0, 0, 0);
    check_eq("pre_flush_mk", bus_if.marker_cnt, 1);
    cyc(1, 0, 8'h00, 0, 0, 1);
    check_eq("flush_ovld", bus_if.out_valid, 0);
    check_eq("flush_irdy", bus_if.in_ready,  0);
    cyc(1, 0, 8'h00, 0, 0, 0);
    check_eq("post_flush_count", bus_if.count,      0);
    check_eq("post_flush_mk",    bus_if.marker_cnt, 0);
    check_eq("post_flush_irdy",  bus_if.in_ready,   1);

    // Reset during simultaneous push+pop
    cyc(1, 1, 8'h05, 0, 0, 0);
    cyc(1, 1, 8'hB2, 0, 0, 0);
    cyc(0, 1, 8'hC3, 1, 0, 0);
    check_eq("mid_rst_irdy",  bus_if.in_ready,   1);
    check_eq("mid_rst_ovld",  bus_if.out_valid,  0);
    check_eq("mid_rst_count", bus_if.count,      0);
    check_eq("mid_rst_mk",    bus_if.marker_cnt, 0);
    check_eq("mid_rst_data",  bus_if.out_data,   0);

    // Random traffic
    begin
      bit p = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) p = ~p;
        cyc($urandom_range(0, 299) != 0,
            $urandom_range(0, 3) != 0,
            8'($urandom_range(0, 7)),
            $urandom_range(0, 2) != 0,
            p,
            $urandom_range(0, 39) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_off_chip_rx_buffer
